// File: rtl/sprite_loader.sv
// Sprite register loader: buffers position/attribute writes in a FIFO and issues them only during vblank.
// Optional drop counter for invalid sprite indices is enabled with SPRITE_LOADER_DROPCNT_EN.
module sprite_loader #(
    parameter int NUM_SPRITES = 4,
    parameter int SEL_W       = 3,
    parameter int DEPTH       = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   vblank,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic                   cmd_kind,
    input  logic [SEL_W-1:0]       cmd_sel,
    input  logic [31:0]            cmd_data,
    output logic [31:0]            data_out,
    output logic [NUM_SPRITES-1:0] load_pos,
    output logic [NUM_SPRITES-1:0] load_att,
    output logic                   busy,
    output logic                   done,
    output logic [7:0]             drop_count
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam int EW = 1 + SEL_W + 32;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t                 r_state;
    logic                   r_busy;
    logic                   r_done;
    logic                   r_vblank_q;
    logic                   r_seen_low;
    logic                   r_cmd_ready;
    logic [AW-1:0]          r_wr_ptr;
    logic [AW-1:0]          r_rd_ptr;
    logic [CW-1:0]          r_count;
    logic [EW-1:0]          r_mem [DEPTH];
    logic [31:0]            r_data_out;
    logic [NUM_SPRITES-1:0] r_load_pos;
    logic [NUM_SPRITES-1:0] r_load_att;

    logic                   w_accept;
    logic                   w_sel_ok;
    logic                   w_push;
    logic                   w_pop;
    logic                   w_rise;
    logic [CW-1:0]          w_count_next;
    logic [31:0]            w_payload;
    logic [EW-1:0]          w_head;
    logic                   w_head_kind;
    logic [SEL_W-1:0]       w_head_sel;
    logic [NUM_SPRITES-1:0] w_hit;

    assign w_accept     = cmd_valid && r_cmd_ready;
    assign w_sel_ok     = 32'(cmd_sel) < NUM_SPRITES;
    assign w_push       = w_accept && w_sel_ok;
    assign w_pop        = (r_state == S_DRAIN) && vblank && (r_count != '0);
    assign w_count_next = r_count + CW'(w_push) - CW'(w_pop);
    // Only a rise after vblank has been seen low counts, so a vblank already high at reset is skipped.
    assign w_rise       = vblank && !r_vblank_q && r_seen_low;
    assign w_payload    = cmd_data & (cmd_kind ? 32'h0000_001F : 32'h0001_FFFF);

    assign w_head      = r_mem[r_rd_ptr];
    assign w_head_kind = w_head[EW-1];
    assign w_head_sel  = w_head[32 +: SEL_W];

    generate
        for (genvar gi = 0; gi < NUM_SPRITES; gi++) begin : g_hit
            assign w_hit[gi] = (w_head_sel == SEL_W'(gi));
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {cmd_kind, cmd_sel, w_payload};
        end
    end

    // Ready is registered from next-cycle occupancy so a push can never land on a full FIFO.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_cmd_ready <= 1'b1;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            r_count     <= w_count_next;
            r_cmd_ready <= (w_count_next != FULL);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_data_out <= '0;
            r_load_pos <= '0;
            r_load_att <= '0;
        end else begin
            r_load_pos <= '0;
            r_load_att <= '0;
            if (w_pop) begin
                r_data_out <= w_head[31:0];
                if (w_head_kind) begin
                    r_load_att <= w_hit;
                end else begin
                    r_load_pos <= w_hit;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_vblank_q <= 1'b0;
            r_seen_low <= !vblank;
        end else begin
            r_vblank_q <= vblank;
            r_seen_low <= r_seen_low || !vblank;
            r_done     <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_rise) begin
                        r_state <= S_DRAIN;
                        r_busy  <= 1'b1;
                    end
                end
                S_DRAIN: begin
                    if (!vblank) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end else if (r_count == '0) begin
                        r_state <= S_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                S_DONE: begin
                    if (!vblank) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

`ifdef SPRITE_LOADER_DROPCNT_EN
    logic       w_drop;
    logic [7:0] r_drop_count;

    assign w_drop = w_accept && !w_sel_ok;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_drop_count <= '0;
        end else if (w_drop && (r_drop_count != 8'hFF)) begin
            r_drop_count <= r_drop_count + 8'd1;
        end
    end

    assign drop_count = r_drop_count;
`else
    assign drop_count = 8'd0;
`endif

    assign cmd_ready = r_cmd_ready;
    assign data_out  = r_data_out;
    assign load_pos  = r_load_pos;
    assign load_att  = r_load_att;
    assign busy      = r_busy;
    assign done      = r_done;

endmodule

// File: tb/tb_sprite_loader.sv
// Directed self-checking bench for sprite_loader: one task per scenario, inline comparisons.
module tb_sprite_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        vblank;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_kind;
    logic [2:0]  cmd_sel;
    logic [31:0] cmd_data;
    logic [31:0] data_out;
    logic [3:0]  load_pos;
    logic [3:0]  load_att;
    logic        busy;
    logic        done;
    logic [7:0]  drop_count;

    int errors = 0;
    int checks = 0;

`ifdef SPRITE_LOADER_DROPCNT_EN
    localparam logic [7:0] EXP_DROP = 8'd2;
`else
    localparam logic [7:0] EXP_DROP = 8'd0;
`endif

    sprite_loader #(.NUM_SPRITES(4), .SEL_W(3), .DEPTH(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .vblank     (vblank),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_kind   (cmd_kind),
        .cmd_sel    (cmd_sel),
        .cmd_data   (cmd_data),
        .data_out   (data_out),
        .load_pos   (load_pos),
        .load_att   (load_att),
        .busy       (busy),
        .done       (done),
        .drop_count (drop_count)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_cmd(input logic kind, input logic [2:0] sel, input logic [31:0] data);
        cmd_valid = 1'b1;
        cmd_kind  = kind;
        cmd_sel   = sel;
        cmd_data  = data;
        step();
        cmd_valid = 1'b0;
        $display("push kind=%0d sel=%0d data=%08h", kind, sel, data);
    endtask

    task automatic test_reset();
        rst = 1'b1; vblank = 1'b0; cmd_valid = 1'b0;
        cmd_kind = 1'b0; cmd_sel = '0; cmd_data = '0;
        step(); step();
        rst = 1'b0;
        step();
        checks++; if (data_out !== 32'h0) begin errors++; $display("FAIL reset_data_out got=%08h exp=00000000", data_out); end
        checks++; if ({load_pos, load_att} !== 8'h00) begin errors++; $display("FAIL reset_strobes got=%02h exp=00", {load_pos, load_att}); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", done); end
        checks++; if (drop_count !== 8'd0) begin errors++; $display("FAIL reset_drop got=%0d exp=0", drop_count); end
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", cmd_ready); end
        $display("reset done");
    endtask

    task automatic test_single_pos();
        push_cmd(1'b0, 3'd2, 32'h0001_2345);
        step();
        checks++; if ({load_pos, load_att} !== 8'h00 || busy !== 1'b0) begin errors++; $display("FAIL pos_no_issue_outside_vblank strobes=%02h busy=%b exp=00/0", {load_pos, load_att}, busy); end
        vblank = 1'b1;
        step();
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL pos_busy got=%b exp=1", busy); end
        step();
        checks++; if (load_pos !== 4'b0100 || load_att !== 4'b0000) begin errors++; $display("FAIL pos_strobe got pos=%b att=%b exp pos=0100 att=0000", load_pos, load_att); end
        checks++; if (data_out !== 32'h0001_2345) begin errors++; $display("FAIL pos_data got=%08h exp=00012345", data_out); end
        step();
        checks++; if (done !== 1'b1 || load_pos !== 4'b0000 || busy !== 1'b0) begin errors++; $display("FAIL pos_done done=%b pos=%b busy=%b exp 1/0000/0", done, load_pos, busy); end
        step();
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL pos_done_pulse got=%b exp=0", done); end
        vblank = 1'b0;
        step(); step();
        $display("single pos write issued");
    endtask

    task automatic test_att_in_vblank();
        vblank = 1'b1;
        push_cmd(1'b1, 3'd0, 32'hFFFF_FFFF);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL att_busy got=%b exp=1", busy); end
        step();
        checks++; if (load_att !== 4'b0001 || load_pos !== 4'b0000) begin errors++; $display("FAIL att_strobe got att=%b pos=%b exp att=0001 pos=0000", load_att, load_pos); end
        checks++; if (data_out !== 32'h0000_001F) begin errors++; $display("FAIL att_mask got=%08h exp=0000001F", data_out); end
        step();
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL att_done got=%b exp=1", done); end
        vblank = 1'b0;
        step(); step();
        $display("attribute write issued");
    endtask

    task automatic test_partial_drain();
        logic        kinds [8] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        logic [2:0]  sels  [8] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd3, 3'd2, 3'd1, 3'd0};
        logic [31:0] datas [8] = '{32'h0000_1111, 32'h0000_00FF, 32'h0003_ABCD, 32'h1234_5675,
                                   32'hFFFF_FFFF, 32'h0000_0007, 32'h0000_0100, 32'h8000_0011};
        logic [31:0] exps  [8] = '{32'h0000_1111, 32'h0000_001F, 32'h0001_ABCD, 32'h0000_0015,
                                   32'h0001_FFFF, 32'h0000_0007, 32'h0000_0100, 32'h0000_0011};
        logic [7:0]  exp_strobe;
        for (int i = 0; i < 8; i++) begin
            push_cmd(kinds[i], sels[i], datas[i]);
            if (i == 6) begin
                checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL fill_ready_at_7 got=%b exp=1", cmd_ready); end
            end
        end
        checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL fill_ready_full got=%b exp=0", cmd_ready); end
        vblank = 1'b1;
        step();
        checks++; if ({load_pos, load_att} !== 8'h00) begin errors++; $display("FAIL partial_rise_strobes got=%02h exp=00", {load_pos, load_att}); end
        for (int k = 0; k < 3; k++) begin
            step();
            exp_strobe = kinds[k] ? {4'b0000, 4'(1 << sels[k])} : {4'(1 << sels[k]), 4'b0000};
            checks++; if ({load_pos, load_att} !== exp_strobe || data_out !== exps[k]) begin errors++; $display("FAIL partial_issue%0d strobes=%02h data=%08h exp=%02h/%08h", k, {load_pos, load_att}, data_out, exp_strobe, exps[k]); end
            $display("issue %0d strobes=%02h data=%08h", k, {load_pos, load_att}, data_out);
            if (k == 2) vblank = 1'b0;
        end
        step();
        checks++; if ({load_pos, load_att} !== 8'h00 || busy !== 1'b0) begin errors++; $display("FAIL partial_stop strobes=%02h busy=%b exp=00/0", {load_pos, load_att}, busy); end
        step();
        checks++; if (data_out !== exps[2] || cmd_ready !== 1'b1) begin errors++; $display("FAIL partial_hold data=%08h ready=%b exp=%08h/1", data_out, cmd_ready, exps[2]); end
        vblank = 1'b1;
        step();
        for (int k = 3; k < 8; k++) begin
            step();
            exp_strobe = kinds[k] ? {4'b0000, 4'(1 << sels[k])} : {4'(1 << sels[k]), 4'b0000};
            checks++; if ({load_pos, load_att} !== exp_strobe || data_out !== exps[k]) begin errors++; $display("FAIL resume_issue%0d strobes=%02h data=%08h exp=%02h/%08h", k, {load_pos, load_att}, data_out, exp_strobe, exps[k]); end
            $display("issue %0d strobes=%02h data=%08h", k, {load_pos, load_att}, data_out);
        end
        step();
        checks++; if (done !== 1'b1 || {load_pos, load_att} !== 8'h00) begin errors++; $display("FAIL resume_done done=%b strobes=%02h exp=1/00", done, {load_pos, load_att}); end
        vblank = 1'b0;
        step(); step();
    endtask

    task automatic test_back_to_back();
        int  q[$];
        int  seq = 0;
        int  issued = 0;
        bit  acc;
        bit  ready_seen = 1'b0;
        bit  done_seen = 1'b0;
        int  s;
        logic [7:0] exp_strobe;
        for (int i = 0; i < 8; i++) begin
            push_cmd(1'(seq % 2), 3'(seq % 4), 32'(seq));
            q.push_back(seq);
            seq++;
        end
        checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL b2b_full_ready got=%b exp=0", cmd_ready); end
        vblank = 1'b1;
        cmd_valid = 1'b1; cmd_kind = 1'(seq % 2); cmd_sel = 3'(seq % 4); cmd_data = 32'(seq);
        for (int c = 0; c < 60 && !done_seen; c++) begin
            acc = cmd_valid && cmd_ready;
            step();
            if (acc) begin
                q.push_back(seq);
                seq++;
                if (seq < 20) begin
                    cmd_kind = 1'(seq % 2); cmd_sel = 3'(seq % 4); cmd_data = 32'(seq);
                end else begin
                    cmd_valid = 1'b0;
                end
            end
            if (cmd_valid && ready_seen) begin
                checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready_steady got=%b exp=1 cycle=%0d", cmd_ready, c); end
            end
            if (cmd_ready === 1'b1) ready_seen = 1'b1;
            if ((load_pos | load_att) !== 4'b0000) begin
                if (q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL b2b_extra_strobe got=%02h data=%08h exp=none", {load_pos, load_att}, data_out);
                end else begin
                    s = q.pop_front();
                    exp_strobe = (s % 2 == 1) ? {4'b0000, 4'(1 << (s % 4))} : {4'(1 << (s % 4)), 4'b0000};
                    checks++; if ({load_pos, load_att} !== exp_strobe || data_out !== 32'(s)) begin errors++; $display("FAIL b2b_order strobes=%02h data=%08h exp=%02h/%08h", {load_pos, load_att}, data_out, exp_strobe, 32'(s)); end
                    issued++;
                    $display("b2b issue seq=%0d strobes=%02h data=%08h", s, {load_pos, load_att}, data_out);
                end
            end
            if (done === 1'b1) done_seen = 1'b1;
        end
        cmd_valid = 1'b0;
        checks++; if (!done_seen) begin errors++; $display("FAIL b2b_timeout done_seen=0 exp=1"); end
        checks++; if (issued != 20 || q.size() != 0) begin errors++; $display("FAIL b2b_count issued=%0d left=%0d exp=20/0", issued, q.size()); end
        vblank = 1'b0;
        step(); step();
    endtask

    task automatic test_invalid();
        push_cmd(1'b0, 3'd5, 32'h0000_0AAA);
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL inv_ready got=%b exp=1", cmd_ready); end
        push_cmd(1'b0, 3'd5, 32'h0000_0BBB);
        push_cmd(1'b0, 3'd1, 32'h0000_0042);
        vblank = 1'b1;
        step();
        step();
        checks++; if (load_pos !== 4'b0010 || load_att !== 4'b0000 || data_out !== 32'h0000_0042) begin errors++; $display("FAIL inv_issue pos=%b att=%b data=%08h exp=0010/0000/00000042", load_pos, load_att, data_out); end
        step();
        checks++; if (done !== 1'b1 || {load_pos, load_att} !== 8'h00) begin errors++; $display("FAIL inv_only_one done=%b strobes=%02h exp=1/00", done, {load_pos, load_att}); end
        checks++; if (drop_count !== EXP_DROP) begin errors++; $display("FAIL inv_drop_count got=%0d exp=%0d", drop_count, EXP_DROP); end
        vblank = 1'b0;
        step(); step();
    endtask

    task automatic test_reset_mid_drain();
        for (int i = 0; i < 4; i++) push_cmd(1'b0, 3'(i), 32'h100 + 32'(i));
        vblank = 1'b1;
        step();
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rst_mid_busy got=%b exp=1", busy); end
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++; if ({load_pos, load_att} !== 8'h00 || cmd_ready !== 1'b1 || busy !== 1'b0 || data_out !== 32'h0) begin errors++; $display("FAIL rst_mid_state strobes=%02h ready=%b busy=%b data=%08h exp=00/1/0/0", {load_pos, load_att}, cmd_ready, busy, data_out); end
        checks++; if (drop_count !== 8'd0) begin errors++; $display("FAIL rst_mid_drop got=%0d exp=0", drop_count); end
        for (int c = 0; c < 5; c++) begin
            step();
            checks++; if ({load_pos, load_att} !== 8'h00 || busy !== 1'b0) begin errors++; $display("FAIL rst_mid_hold%0d strobes=%02h busy=%b exp=00/0", c, {load_pos, load_att}, busy); end
        end
        vblank = 1'b0;
        step();
        vblank = 1'b1;
        step();
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rst_next_busy got=%b exp=1", busy); end
        step();
        checks++; if (done !== 1'b1 || {load_pos, load_att} !== 8'h00) begin errors++; $display("FAIL rst_fifo_empty done=%b strobes=%02h exp=1/00", done, {load_pos, load_att}); end
        vblank = 1'b0;
        step();
        $display("reset mid drain done");
    endtask

    initial begin
        test_reset();
        test_single_pos();
        test_att_in_vblank();
        test_partial_drain();
        test_back_to_back();
        test_invalid();
        test_reset_mid_drain();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sprite_loader.md
Name: sprite_loader

Overview:
- Register-side driver for a bank of sprite engines.
- Accepts sprite position and attribute write commands from the control side through a valid/ready interface and buffers them in a FIFO.
- Issues them to the sprites as a shared `data_out` bus with one-hot `load_pos` / `load_att` strobes.
- Issues writes only during vertical blanking, so a sprite never moves or changes mid-frame.

Parameters:
- NUM_SPRITES, 4, number of sprite engines driven; one strobe bit each.
- SEL_W, 3, width of the sprite index field; indices >= NUM_SPRITES are invalid.
- DEPTH, 8, command FIFO depth in entries; power of two, >= 2.

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst  input  1  synchronous, active-high reset.
- vblank  input  1  high during vertical blanking; synchronous to clk.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  FIFO can accept; high when not full.
- cmd_kind  input  1  0 = position write, 1 = attribute write.
- cmd_sel  input  SEL_W  target sprite index.
- cmd_data  input  32  payload. Position: x in [16:8], y in [7:0]. Attribute: visible [0], h_flip [1], v_flip [2], depth [4:3].
- data_out  output  32  shared payload bus to all sprites.
- load_pos  output  NUM_SPRITES  one-hot position strobe.
- load_att  output  NUM_SPRITES  one-hot attribute strobe.
- busy  output  1  high while the FSM is in DRAIN.
- done  output  1  one-cycle pulse when the FIFO empties within a vblank.
- drop_count  output  8  count of dropped invalid-index commands (see Optional Feature).

Behaviour:
- Reset: `data_out`=0, `load_pos`=0, `load_att`=0, `busy`=0, `done`=0, `drop_count`=0.
  - FIFO emptied; `cmd_ready`=1 the cycle after reset deasserts.
  - FSM to IDLE; `vblank_q`=0.
- Push: a command is written when `cmd_valid && cmd_ready`.
  - Push while full is impossible because `cmd_ready` is low.
  - Push and pop in the same cycle are both performed; occupancy is unchanged.
  - At full occupancy, a same-cycle pop does not raise `cmd_ready` until the next cycle; `cmd_ready` is registered from occupancy.
- Invalid index (`cmd_sel` >= NUM_SPRITES): the command is accepted (`cmd_ready` honoured) but not stored.
- `vblank_q` is `vblank` registered. Rising edge = `vblank && !vblank_q`.
- FSM states:
  - IDLE: on a vblank rising edge, go to DRAIN. A vblank already high at reset is ignored until its next rising edge.
  - DRAIN:
    - Each cycle with `vblank` high and the FIFO non-empty, pop one entry.
    - If `vblank` falls, go to IDLE; remaining entries wait for the next vblank.
    - If the FIFO is empty with `vblank` high, pulse `done` for one cycle and go to DONE. This includes entering DRAIN with an already-empty FIFO.
  - DONE: go to IDLE when `vblank` is low. Commands pushed during DONE wait for the next vblank.
- Issue timing: a popped entry drives outputs on the next cycle (registered, latency 1), for exactly one cycle.
  - Strobe: `load_pos[sel]` if kind=0, else `load_att[sel]`.
  - `data_out` payload masked: kind 0 keeps [16:0]; kind 1 keeps [4:0]; all other bits are 0.
  - A strobe may land in the cycle after `vblank` falls; this is permitted.
- At most one strobe bit is high in any cycle; strobes are 0 in cycles with no pop.
- `data_out` holds its last value when idle.
- Throughput: one write per clock during vblank.
- Ordering: strict FIFO order, including same-sprite pos/att sequences.

Optional Feature:
- Macro: SPRITE_LOADER_DROPCNT_EN.
- Defined:
  - `drop_count` increments by 1 per accepted invalid-index command.
  - It saturates at 255 and is cleared only by `rst`.
- Undefined: `drop_count` is tied to 0 and invalid commands are silently discarded.
- All other behaviour is identical in both builds.

Test Plan:
- Reset, vblank low, push pos sel=2 data=0x0001_2345 -> no strobes. Raise vblank -> `busy`=1; one cycle later `load_pos`=4'b0100 and `data_out`=0x0001_2345 for one cycle; next cycle `done`=1 for one cycle.
- Push att sel=0 data=0xFFFF_FFFF during vblank -> `load_att`=4'b0001, `data_out`=0x0000_001F.
- Push 8 commands with vblank low -> `cmd_ready`=0 after the 8th. Raise vblank for 3 cycles -> exactly 3 strobes in order; 5 remain. Next vblank -> remaining 5 issued in order, then `done`.
- Fill FIFO, then in vblank hold `cmd_valid` with pops each cycle -> occupancy is steady once `cmd_ready` reasserts; no command lost or duplicated (scoreboard compare).
- Push sel=5 twice, then sel=1 -> only `load_pos`=4'b0010 seen in vblank; `drop_count`=2 with SPRITE_LOADER_DROPCNT_EN defined, 0 without.
- Assert `rst` for one cycle mid-DRAIN with 4 entries queued -> all strobes 0 the next cycle, FIFO empty, `cmd_ready`=1; vblank still high -> no issue until the next vblank rising edge.
